// File: rtl/life_rule_engine_pkg.sv
// Shared types and constants for the Life rule engine: coordinate and rule-mask types,
// default B3/S23 rule, engine state encoding and the rule-mask lookup helper.
package life_rule_engine_pkg;

    localparam int LOG_MAX_SPEED = 3;
    localparam int POS_W         = 8;

    typedef logic [POS_W-1:0] pos_t;
    typedef logic [8:0]       rule_mask_t;

    localparam rule_mask_t BIRTH_DEFAULT   = 9'h008;
    localparam rule_mask_t SURVIVE_DEFAULT = 9'h00C;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } eng_state_t;

    // Neighbour counts never exceed 8, so the index always lands inside the mask.
    function automatic logic rule_lookup(input rule_mask_t mask, input logic [3:0] n);
        return mask[n];
    endfunction

endpackage

// File: rtl/life_line_buffer.sv
// One-bit shift register of DEPTH stages with enable; q is the bit written DEPTH enables ago.
module life_line_buffer #(
    parameter int DEPTH = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (en) begin
            sr <= {sr[DEPTH-2:0], d};
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/life_rule_engine.sv
// Streaming Game-of-Life rule engine: consumes one generation row-major and emits the
// next one through a two-line-buffer 3x3 window, with frame-rate division and cursor toggle.
module life_rule_engine
    import life_rule_engine_pkg::*;
#(
    parameter int BOARD_W = 64,
    parameter int BOARD_H = 48
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     valid_in,
    output logic                     ready_out,
    input  logic                     alive_in,
    input  logic [8:0]               birth_mask_in,
    input  logic [8:0]               survive_mask_in,
    input  logic [LOG_MAX_SPEED-1:0] speed_in,
    input  logic [POS_W-1:0]         cursor_x_in,
    input  logic [POS_W-1:0]         cursor_y_in,
    input  logic                     cursor_click_in,
    output logic                     valid_out,
    output logic                     alive_out,
    output logic [POS_W-1:0]         x_out,
    output logic [POS_W-1:0]         y_out,
    output logic                     frame_done_out
);

    localparam int CNT_W = $clog2(BOARD_W + 2);
    localparam int FC_W  = (1 << LOG_MAX_SPEED) - 1;
    localparam pos_t X_LAST = pos_t'(BOARD_W - 1);
    localparam pos_t Y_LAST = pos_t'(BOARD_H - 1);
    localparam logic [CNT_W-1:0] PRIME_N    = CNT_W'(BOARD_W + 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(BOARD_W);

    function automatic logic [3:0] count_ones8(input logic [7:0] v);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            s = s + {3'b000, v[i]};
        end
        return s;
    endfunction

    // All-ones for speed >= LOG2 of the counter range falls out of the modular subtraction.
    function automatic logic [FC_W-1:0] speed_mask(input logic [LOG_MAX_SPEED-1:0] s);
        return (FC_W'(1) << s) - FC_W'(1);
    endfunction

    eng_state_t state_q, state_d;

    pos_t             in_x, in_y, cen_x, cen_y;
    logic [CNT_W-1:0] flush_cnt, prime_cnt;
    logic [FC_W-1:0]  frame_cnt;
    rule_mask_t       birth_q, survive_q;
    logic [LOG_MAX_SPEED-1:0] speed_q;
    pos_t             cur_x_q, cur_y_q;
    logic             click_q, advance_q;

    logic accept, beat, cell_in, first_beat, last_in, flush_end, centre_vld;
    logic row1, row2;

    assign ready_out  = (state_q == ST_RUN);
    assign accept     = valid_in && ready_out;
    assign beat       = accept || (state_q == ST_FLUSH);
    assign cell_in    = ready_out && alive_in;
    assign first_beat = accept && (in_x == '0) && (in_y == '0);
    assign last_in    = accept && (in_x == X_LAST) && (in_y == Y_LAST);
    assign flush_end  = (state_q == ST_FLUSH) && (flush_cnt == FLUSH_LAST);
    assign centre_vld = beat && (prime_cnt == PRIME_N);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (last_in)   state_d = ST_FLUSH;
            ST_FLUSH: if (flush_end) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= ST_RUN;
            in_x      <= '0;
            in_y      <= '0;
            cen_x     <= '0;
            cen_y     <= '0;
            flush_cnt <= '0;
            prime_cnt <= '0;
            frame_cnt <= '0;
            birth_q   <= '0;
            survive_q <= '0;
            speed_q   <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            click_q   <= 1'b0;
            advance_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                if (in_x == X_LAST) begin
                    in_x <= '0;
                    in_y <= (in_y == Y_LAST) ? '0 : in_y + pos_t'(1);
                end else begin
                    in_x <= in_x + pos_t'(1);
                end
            end
            if (state_q == ST_FLUSH) begin
                flush_cnt <= flush_end ? '0 : flush_cnt + CNT_W'(1);
            end
            // The window centre trails the input by BOARD_W+1 beats within each frame.
            if (flush_end) begin
                prime_cnt <= '0;
            end else if (beat && (prime_cnt != PRIME_N)) begin
                prime_cnt <= prime_cnt + CNT_W'(1);
            end
            if (centre_vld) begin
                if (cen_x == X_LAST) begin
                    cen_x <= '0;
                    cen_y <= (cen_y == Y_LAST) ? '0 : cen_y + pos_t'(1);
                end else begin
                    cen_x <= cen_x + pos_t'(1);
                end
            end
            if (flush_end) begin
                frame_cnt <= (frame_cnt + FC_W'(1)) & speed_mask(speed_q);
            end
            if (first_beat) begin
                birth_q   <= birth_mask_in;
                survive_q <= survive_mask_in;
                speed_q   <= speed_in;
                cur_x_q   <= cursor_x_in;
                cur_y_q   <= cursor_y_in;
                click_q   <= cursor_click_in && (cursor_x_in <= X_LAST) && (cursor_y_in <= Y_LAST);
                advance_q <= ((frame_cnt & speed_mask(speed_in)) == '0);
            end
        end
    end

    life_line_buffer #(.DEPTH(BOARD_W)) u_lb_row1 (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .en    (beat),
        .d     (cell_in),
        .q     (row1)
    );

    life_line_buffer #(.DEPTH(BOARD_W)) u_lb_row2 (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .en    (beat),
        .d     (row1),
        .q     (row2)
    );

    // ---- p0: 3x3 window, bit 2 = left column, bit 1 = centre, bit 0 = right ----
    logic [2:0] top_p0, mid_p0, bot_p0;
    pos_t       cx_p0, cy_p0;
    logic       vld_p0;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            top_p0 <= '0;
            mid_p0 <= '0;
            bot_p0 <= '0;
            cx_p0  <= '0;
            cy_p0  <= '0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= centre_vld;
            if (beat) begin
                top_p0 <= {top_p0[1:0], row2};
                mid_p0 <= {mid_p0[1:0], row1};
                bot_p0 <= {bot_p0[1:0], cell_in};
            end
            if (centre_vld) begin
                cx_p0 <= cen_x;
                cy_p0 <= cen_y;
            end
        end
    end

    logic       use_l, use_r, use_t, use_b, next_alive, toggle;
    logic [7:0] nbr;
    logic [3:0] n_cnt;

    always_comb begin
        use_l = (cx_p0 != '0);
        use_r = (cx_p0 != X_LAST);
        use_t = (cy_p0 != '0);
        use_b = (cy_p0 != Y_LAST);
        nbr   = {top_p0[2] & use_t & use_l, top_p0[1] & use_t, top_p0[0] & use_t & use_r,
                 mid_p0[2] & use_l,                            mid_p0[0] & use_r,
                 bot_p0[2] & use_b & use_l, bot_p0[1] & use_b, bot_p0[0] & use_b & use_r};
        n_cnt = count_ones8(nbr);
        next_alive = mid_p0[1];
        if (advance_q) begin
            next_alive = mid_p0[1] ? rule_lookup(survive_q, n_cnt) : rule_lookup(birth_q, n_cnt);
        end
        toggle = click_q && (cx_p0 == cur_x_q) && (cy_p0 == cur_y_q);
    end

    // ---- p1: registered next-generation cell ----
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_out      <= 1'b0;
            alive_out      <= 1'b0;
            x_out          <= '0;
            y_out          <= '0;
            frame_done_out <= 1'b0;
        end else begin
            valid_out      <= vld_p0;
            frame_done_out <= vld_p0 && (cx_p0 == X_LAST) && (cy_p0 == Y_LAST);
            if (vld_p0) begin
                alive_out <= next_alive ^ toggle;
                x_out     <= cx_p0;
                y_out     <= cy_p0;
            end
        end
    end

endmodule

// File: doc/life_rule_engine.md
LIFE_RULE_ENGINE -- requirements
Module: life_rule_engine

Interface
REQ-001 SHALL have parameter BOARD_W, default 64, meaning cells per row.
REQ-002 SHALL have parameter BOARD_H, default 48, meaning rows per board.
REQ-003 SHALL have these ports; one clock; reset is asynchronous and active-low:
- clk_in  in  1  sole clock.
- rst_n_in  in  1  async active-low reset.
- valid_in  in  1  current-generation cell offered.
- ready_out  out  1  engine accepts a cell this cycle.
- alive_in  in  1  offered cell state.
- birth_mask_in  in  9  bit n set: dead cell with n neighbours is born.
- survive_mask_in  in  9  bit n set: live cell with n neighbours survives.
- speed_in  in  LOG_MAX_SPEED  advance once per 2^speed_in frames.
- cursor_x_in, cursor_y_in  in  pos_t  cursor cell.
- cursor_click_in  in  1  toggle cell under cursor.
- valid_out  out  1  next-generation cell valid.
- alive_out  out  1  next-generation cell state.
- x_out, y_out  out  pos_t  coordinates of alive_out.
- frame_done_out  out  1  last cell of frame emitted.

Function
REQ-004 SHALL accept a beat when valid_in && ready_out; cells arrive row-major, (0,0) first; x/y counters held internally, x wraps at BOARD_W-1, y wraps at BOARD_H-1.
REQ-005 SHALL keep two BOARD_W-deep line buffers plus a 3x3 window; neighbour count 4 bits, range 0..8.
REQ-006 SHALL emit cell at linear index k, registered, one cycle after the beat of index k+BOARD_W+1 is processed (accepted or flush beat); valid_out high for exactly one cycle per cell.
REQ-007 SHALL count neighbours outside the board as dead; no wrap-around between columns or rows.
REQ-008 SHALL compute next = alive ? survive_mask[n] : birth_mask[n] on advancing frames.
REQ-009 SHALL sample birth/survive masks, speed_in, cursor and click on the beat of index 0 and hold them for that frame.
REQ-010 SHALL hold a frame counter modulo 2^speed; frame advances when counter = 0; on non-advancing frames alive_out = alive_in of same cell, same latency.
REQ-011 SHALL, when sampled click = 1 and cursor inside the board, invert alive_out for the cursor cell after rule evaluation, on all frames; cursor outside board has no effect.
REQ-012 SHALL implement FSM RUN -> FLUSH on acceptance of index BOARD_W*BOARD_H-1; FLUSH runs exactly BOARD_W+1 cycles of internal dead-cell beats, then -> RUN.
REQ-013 SHALL drive ready_out = (state == RUN); valid_in during FLUSH is ignored, not accepted.
REQ-014 SHALL pulse frame_done_out with valid_out of cell (BOARD_W-1, BOARD_H-1), once per frame.
REQ-015 SHALL tolerate gaps in valid_in in RUN; no output is produced without a processed beat.

Reset
REQ-016 SHALL on rst_n_in low immediately clear: state RUN, counters, frame counter, line buffers, window, valid_out, alive_out, x_out, y_out, frame_done_out to 0; ready_out reads 1.
REQ-017 SHALL discard a partial frame on mid-frame reset; next accepted beat is (0,0); no stale output or frame_done_out.

Structure
REQ-018 SHALL take LOG_MAX_SPEED, pos_t and a new rule_mask_t (9 bits) from the shared common package; default B3/S23 masks (0x008, 0x00C) as package constants.
REQ-019 SHALL instantiate sub-module life_line_buffer (parametrised depth, 1-bit shift register with enable) twice.

Verification (BOARD_W=8, BOARD_H=6)
REQ-020 Blinker (2..4,3), masks 0x008/0x00C, speed 0 -> alive only (3,2),(3,3),(3,4); 48 valid_out; frame_done_out once at (7,5).
REQ-021 Corner L (0,0),(1,0),(0,1) -> 2x2 block at (0..1,0..1); (7,5),(7,0),(0,5) dead (no wrap).
REQ-022 Masks 0x048/0x00C, dead (3,3) with 6 live neighbours -> (3,3) alive; with 0x008 birth -> dead.
REQ-023 speed_in=2, blinker over 4 frames -> frame 0 rotates, frames 1-3 pass through unchanged.
REQ-024 Empty board, click at (5,4) -> only (5,4) alive; click at (9,0) -> all dead; ready_out low exactly 9 cycles after each last input.
REQ-025 Reset asserted after 20 accepted beats -> outputs 0 at once, ready_out 1; next full frame yields REQ-020 result.
